// File: rtl/contador_display_mux_if.sv
// ---------------------------------------------------------------------------
// contador_display_mux_if : control inputs and display outputs of the counter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface contador_display_mux_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    en;
  logic                    up_dn;
  logic                    bcd_mode;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [7:0]              segmentos;
  logic [NUM_DIGITS-1:0]   sel_seg;
  logic [4*NUM_DIGITS-1:0] contador_reg;
  logic                    wrap;

  modport master (
    output en, up_dn, bcd_mode, load, load_val,
    input  segmentos, sel_seg, contador_reg, wrap
  );

  modport slave (
    input  en, up_dn, bcd_mode, load, load_val,
    output segmentos, sel_seg, contador_reg, wrap
  );
endinterface

`default_nettype wire

// File: rtl/contador_display_mux.sv
// ---------------------------------------------------------------------------
// contador_display_mux : N-digit BCD/hex up/down counter, multiplexed 7-seg drive
// Option macro CONTADOR_LZB_EN enables leading-zero blanking.   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module contador_display_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 12000000,
  parameter int SCAN_DIV       = 12000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  wire logic               clk,
  input  wire logic               rst_n,
  contador_display_mux_if.slave   bus
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [TW-1:0]         TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0]         SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_XOR   = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_XOR   = {NUM_DIGITS{SEL_ACTIVE_LOW != 0}};
  localparam logic [7:0]            SEG_RST   = 8'h3F ^ SEG_XOR;
  localparam logic [NUM_DIGITS-1:0] SEL_RST   = NUM_DIGITS'(1) ^ SEL_XOR;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      default: s = 8'h71;
    endcase
    return s;
  endfunction

  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         contador_q, contador_d;
  logic                  wrap_q, wrap_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            seg_q, seg_d;

  logic                  tick;
  logic                  step;
  logic                  scan_term;
  logic [CW-1:0]         step_val;
  logic                  step_carry;
  logic [3:0]            dig;
  logic [3:0]            digit_sel;
  logic                  blank;

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign step      = tick && bus.en && !bus.load;
  assign scan_term = (scan_cnt_q == SCAN_LAST);

  // Ripple carry (up) or borrow (down) through every digit in one cycle.
  always_comb begin
    step_val   = contador_q;
    step_carry = 1'b1;
    dig        = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      dig = contador_q[4*k +: 4];
      if (step_carry) begin
        if (bus.up_dn) begin
          if (bus.bcd_mode) begin
            if (dig >= 4'd9) begin
              dig        = 4'd0;
              step_carry = 1'b1;
            end else begin
              dig        = dig + 4'd1;
              step_carry = 1'b0;
            end
          end else begin
            step_carry = (dig == 4'hF);
            dig        = dig + 4'd1;
          end
        end else begin
          if (bus.bcd_mode) begin
            if (dig == 4'd0) begin
              dig        = 4'd9;
              step_carry = 1'b1;
            end else if (dig > 4'd9) begin
              dig        = 4'd9;
              step_carry = 1'b0;
            end else begin
              dig        = dig - 4'd1;
              step_carry = 1'b0;
            end
          end else begin
            step_carry = (dig == 4'h0);
            dig        = dig - 4'd1;
          end
        end
      end
      step_val[4*k +: 4] = dig;
    end
  end

  always_comb begin
    tick_cnt_d = (bus.load || tick) ? '0 : tick_cnt_q + TW'(1);
    if (bus.load) begin
      contador_d = bus.load_val;
    end else if (step) begin
      contador_d = step_val;
    end else begin
      contador_d = contador_q;
    end
    wrap_d = step && step_carry;
  end

  // Display fields come from the next index and next count so that
  // sel_seg, segmentos and contador_reg always agree after each edge.
  always_comb begin
    scan_cnt_d = scan_term ? '0 : scan_cnt_q + SW'(1);
    idx_d      = idx_q;
    if (scan_term) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
    digit_sel = 4'h0;
    sel_d     = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_d == IW'(k)) begin
        digit_sel = contador_d[4*k +: 4];
        sel_d[k]  = 1'b1;
      end
    end
    sel_d = sel_d ^ SEL_XOR;
`ifdef CONTADOR_LZB_EN
    blank = (idx_d != '0) && ((contador_d >> {idx_d, 2'b00}) == '0);
`else
    blank = 1'b0;
`endif
    seg_d = (blank ? 8'h00 : seg_decode(digit_sel)) ^ SEG_XOR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
      contador_q <= '0;
      wrap_q     <= 1'b0;
      sel_q      <= SEL_RST;
      seg_q      <= SEG_RST;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      contador_q <= contador_d;
      wrap_q     <= wrap_d;
      sel_q      <= sel_d;
      seg_q      <= seg_d;
    end
  end

  assign bus.contador_reg = contador_q;
  assign bus.wrap         = wrap_q;
  assign bus.sel_seg      = sel_q;
  assign bus.segmentos    = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_contador_display_mux.sv
// ---------------------------------------------------------------------------
// tb_contador_display_mux : directed bench, NUM_DIGITS=2 TICK_DIV=4 SCAN_DIV=2
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_contador_display_mux;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  contador_display_mux_if #(.NUM_DIGITS(2)) bus ();

  contador_display_mux #(
    .NUM_DIGITS    (2),
    .TICK_DIV      (4),
    .SCAN_DIV      (2),
    .SEG_ACTIVE_LOW(0),
    .SEL_ACTIVE_LOW(0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef CONTADOR_LZB_EN
  localparam logic [7:0] LEAD_ZERO_SEG = 8'h00;
`else
  localparam logic [7:0] LEAD_ZERO_SEG = 8'h3F;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Load a value with en=1, then one full prescaler period later check the step.
  task automatic run_vec(input string tag, input logic bcd, input logic up,
                         input logic [7:0] val, input logic [7:0] exp, input logic exp_wrap);
    bus.bcd_mode = bcd;
    bus.up_dn    = up;
    bus.en       = 1'b1;
    bus.load_val = val;
    bus.load     = 1'b1;
    clocks(1);
    bus.load = 1'b0;
    check_val({tag, "_held"}, 32'(bus.contador_reg), 32'(val));
    clocks(4);
    check_val({tag, "_val"}, 32'(bus.contador_reg), 32'(exp));
    check_val({tag, "_wrap"}, 32'(bus.wrap), 32'(exp_wrap));
  endtask

  logic [1:0] exp_sel [6] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10};
  logic [7:0] exp_seg [6] = '{8'h5B, 8'h66, 8'h66, 8'h5B, 8'h5B, 8'h66};

  initial begin
    #100000;
    $display("FAIL watchdog expired got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.up_dn    = 1'b0;
    bus.bcd_mode = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 8'h00;

    clocks(2);
    check_val("rst_cnt",  32'(bus.contador_reg), 32'h00);
    check_val("rst_sel",  32'(bus.sel_seg),      32'h1);
    check_val("rst_seg",  32'(bus.segmentos),    32'h3F);
    check_val("rst_wrap", 32'(bus.wrap),         32'h0);
    rst_n = 1'b1;

    // BCD up 98 -> 99 -> 00 with a one-cycle wrap
    bus.bcd_mode = 1'b1; bus.up_dn = 1'b1; bus.en = 1'b1;
    bus.load_val = 8'h98; bus.load = 1'b1;
    clocks(1);
    bus.load = 1'b0;
    check_val("bcd_load", 32'(bus.contador_reg), 32'h98);
    clocks(3);
    check_val("bcd_pre",  32'(bus.contador_reg), 32'h98);
    clocks(1);
    check_val("bcd_99",   32'(bus.contador_reg), 32'h99);
    check_val("bcd_99_w", 32'(bus.wrap),         32'h0);
    clocks(4);
    check_val("bcd_00",   32'(bus.contador_reg), 32'h00);
    check_val("bcd_00_w", 32'(bus.wrap),         32'h1);
    clocks(1);
    check_val("bcd_w_end", 32'(bus.wrap),        32'h0);

    // Hex down 00 -> FF with wrap, then hold with en=0
    bus.bcd_mode = 1'b0; bus.up_dn = 1'b0;
    bus.load_val = 8'h00; bus.load = 1'b1;
    clocks(1);
    bus.load = 1'b0;
    clocks(4);
    check_val("hex_ff",   32'(bus.contador_reg), 32'hFF);
    check_val("hex_ff_w", 32'(bus.wrap),         32'h1);
    clocks(1);
    check_val("hex_w_end", 32'(bus.wrap),        32'h0);
    bus.en = 1'b0;
    clocks(8);
    check_val("hold",     32'(bus.contador_reg), 32'hFF);

    // Prescaler is now 1; two edges later the tick cycle coincides with load
    clocks(2);
    bus.en = 1'b1; bus.up_dn = 1'b1;
    bus.load_val = 8'h42; bus.load = 1'b1;
    clocks(1);
    bus.load = 1'b0;
    check_val("ld_win",   32'(bus.contador_reg), 32'h42);
    check_val("ld_win_w", 32'(bus.wrap),         32'h0);
    clocks(3);
    check_val("ld_hold",  32'(bus.contador_reg), 32'h42);
    clocks(1);
    check_val("ld_step",  32'(bus.contador_reg), 32'h43);

    run_vec("bcd_up_0a", 1'b1, 1'b1, 8'h0A, 8'h10, 1'b0);
    run_vec("bcd_dn_00", 1'b1, 1'b0, 8'h00, 8'h99, 1'b1);
    run_vec("bcd_dn_0a", 1'b1, 1'b0, 8'h0A, 8'h09, 1'b0);
    run_vec("bcd_dn_10", 1'b1, 1'b0, 8'h10, 8'h09, 1'b0);
    run_vec("hex_up_ff", 1'b0, 1'b1, 8'hFF, 8'h00, 1'b1);
    run_vec("hex_up_3f", 1'b0, 1'b1, 8'h3F, 8'h40, 1'b0);
    run_vec("hex_dn_80", 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0);

    // Asynchronous reset in the middle of a clock cycle while counting
    bus.bcd_mode = 1'b0; bus.up_dn = 1'b1; bus.en = 1'b1;
    clocks(2);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_cnt",  32'(bus.contador_reg), 32'h00);
    check_val("mid_rst_sel",  32'(bus.sel_seg),      32'h1);
    check_val("mid_rst_seg",  32'(bus.segmentos),    32'h3F);
    check_val("mid_rst_wrap", 32'(bus.wrap),         32'h0);
    clocks(1);
    rst_n = 1'b1;

    // Scan: from reset, the digit index changes every second edge
    bus.en = 1'b0;
    bus.load_val = 8'h42; bus.load = 1'b1;
    for (int i = 0; i < 6; i++) begin
      clocks(1);
      bus.load = 1'b0;
      check_val($sformatf("scan_sel%0d", i), 32'(bus.sel_seg),   32'(exp_sel[i]));
      check_val($sformatf("scan_seg%0d", i), 32'(bus.segmentos), 32'(exp_seg[i]));
    end
    check_val("scan_cnt", 32'(bus.contador_reg), 32'h42);

    // Leading zero on digit 1 of value 07
    bus.load_val = 8'h07; bus.load = 1'b1;
    clocks(1);
    bus.load = 1'b0;
    check_val("lz_sel_hi", 32'(bus.sel_seg),   32'h2);
    check_val("lz_seg_hi", 32'(bus.segmentos), 32'(LEAD_ZERO_SEG));
    clocks(1);
    check_val("lz_sel_lo", 32'(bus.sel_seg),   32'h1);
    check_val("lz_seg_lo", 32'(bus.segmentos), 32'h07);
    clocks(2);
    check_val("lz_seg_hi2", 32'(bus.segmentos), 32'(LEAD_ZERO_SEG));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
